// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor: a table of 2-bit saturating counters indexed by PC,
// execute-stage branch resolution with redirect/flush, and saturating perf counters.
module branch_predict_unit #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned INDEX_LSB   = 2,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  f_pc,
    output logic             f_predTaken,
    input  logic             e_valid,
    input  logic             e_branch,
    input  logic             e_forceJump,
    input  logic             e_opCode_3,
    input  logic [2:0]       e_funct3,
    input  logic [3:0]       e_flags,
    input  logic [XLEN-1:0]  e_pc,
    input  logic             e_predTaken,
    output logic [1:0]       PCSrc,
    output logic             mispredict,
    output logic [CNT_W-1:0] branchCount,
    output logic [CNT_W-1:0] mispredCount
);

    localparam int unsigned IDX_W = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;

    localparam logic [1:0] PCSRC_NONE    = 2'b00;
    localparam logic [1:0] PCSRC_IMM     = 2'b01;
    localparam logic [1:0] PCSRC_JALR    = 2'b10;
    localparam logic [1:0] PCSRC_RECOVER = 2'b11;

    logic [1:0]       bht [BHT_ENTRIES];
    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] e_idx;
    logic             flag_zero;
    logic             flag_neg;
    logic             flag_carry;
    logic             flag_ovf;
    logic             actual_taken;
    logic             update;
    logic [1:0]       cur_cnt;
    logic [1:0]       next_cnt;

    // Upper PC bits alias into the table by design.
    logic             unused_pc_bits;
    assign unused_pc_bits = ^{f_pc, e_pc};

    assign f_idx = f_pc[INDEX_LSB +: IDX_W];
    assign e_idx = e_pc[INDEX_LSB +: IDX_W];

    assign f_predTaken = reset ? 1'b0 : bht[f_idx][1];

    assign flag_zero  = e_flags[0];
    assign flag_neg   = e_flags[1];
    assign flag_carry = e_flags[2];
    assign flag_ovf   = e_flags[3];

    // Branch condition from ALU flags of rs1 - rs2.
    always_comb begin
        actual_taken = 1'b0;
        unique case (e_funct3)
            3'b000:  actual_taken = flag_zero;
            3'b001:  actual_taken = ~flag_zero;
            3'b100:  actual_taken = flag_neg ^ flag_ovf;
            3'b101:  actual_taken = ~(flag_neg ^ flag_ovf);
            3'b110:  actual_taken = ~flag_carry;
            3'b111:  actual_taken = flag_carry;
            default: actual_taken = 1'b0;
        endcase
    end

    // Redirect selection; jumps take priority over conditional branches.
    always_comb begin
        PCSrc      = PCSRC_NONE;
        mispredict = 1'b0;
        if (!reset && e_valid) begin
            if (e_forceJump) begin
                PCSrc = e_opCode_3 ? PCSRC_IMM : PCSRC_JALR;
            end else if (e_branch) begin
                mispredict = actual_taken ^ e_predTaken;
                if (actual_taken && !e_predTaken) begin
                    PCSrc = PCSRC_IMM;
                end else if (!actual_taken && e_predTaken) begin
                    PCSrc = PCSRC_RECOVER;
                end
            end
        end
    end

    assign update  = e_valid & e_branch & ~e_forceJump;
    assign cur_cnt = bht[e_idx];

    always_comb begin
        next_cnt = cur_cnt;
        if (actual_taken) begin
            if (cur_cnt != 2'b11) next_cnt = cur_cnt + 2'(1);
        end else begin
            if (cur_cnt != 2'b00) next_cnt = cur_cnt - 2'(1);
        end
    end

    // Table and perf counters; reset wins over a same-edge update.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
                bht[i] <= 2'b01;
            end
            branchCount  <= '0;
            mispredCount <= '0;
        end else if (update) begin
            bht[e_idx] <= next_cnt;
            if (branchCount != {CNT_W{1'b1}}) begin
                branchCount <= branchCount + CNT_W'(1);
            end
            if (mispredict && (mispredCount != {CNT_W{1'b1}})) begin
                mispredCount <= mispredCount + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: the driver predicts each cycle's outputs
// from a behavioural model, a negedge monitor pops and compares.
module tb_branch_predict_unit;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned ENTRIES = 64;
    localparam int unsigned CW      = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [31:0]     f_pc;
    logic            f_predTaken;
    logic            e_valid;
    logic            e_branch;
    logic            e_forceJump;
    logic            e_opCode_3;
    logic [2:0]      e_funct3;
    logic [3:0]      e_flags;
    logic [31:0]     e_pc;
    logic            e_predTaken;
    logic [1:0]      PCSrc;
    logic            mispredict;
    logic [CW-1:0]   branchCount;
    logic [CW-1:0]   mispredCount;

    branch_predict_unit #(
        .XLEN(XLEN), .BHT_ENTRIES(ENTRIES), .INDEX_LSB(2), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .f_pc(f_pc), .f_predTaken(f_predTaken),
        .e_valid(e_valid), .e_branch(e_branch), .e_forceJump(e_forceJump),
        .e_opCode_3(e_opCode_3), .e_funct3(e_funct3), .e_flags(e_flags),
        .e_pc(e_pc), .e_predTaken(e_predTaken), .PCSrc(PCSrc),
        .mispredict(mispredict), .branchCount(branchCount), .mispredCount(mispredCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        string    tag;
        bit [1:0] pcsrc;
        bit       mis;
        bit       pred;
        bit       cnt_known;
        int       bc;
        int       mc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference state: counter strength per entry and event tallies.
    int   tbl [ENTRIES];
    int   bc_m = 0;
    int   mc_m = 0;
    bit   cnt_known = 1'b0;
    int   cnt_max = (1 << CW) - 1;

    function automatic int idx_of(input bit [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    // One cycle: operands a,b define the comparison; flags are what an ALU would produce for a-b.
    task automatic drive(input bit rst, input bit v, input bit br, input bit fj, input bit op3,
                         input bit [2:0] f3, input bit [31:0] a, input bit [31:0] b,
                         input bit [31:0] epc, input bit ept, input bit [31:0] fpc,
                         input string tag);
        bit [31:0] diff;
        bit        taken;
        exp_t      e;
        int        k;
        diff = a - b;
        unique case (f3)
            3'd0:    taken = (a == b);
            3'd1:    taken = (a != b);
            3'd4:    taken = ($signed(a) <  $signed(b));
            3'd5:    taken = ($signed(a) >= $signed(b));
            3'd6:    taken = (a <  b);
            3'd7:    taken = (a >= b);
            default: taken = 1'b0;
        endcase
        reset       = rst;
        e_valid     = v;
        e_branch    = br;
        e_forceJump = fj;
        e_opCode_3  = op3;
        e_funct3    = f3;
        e_flags     = {(a[31] != b[31]) && (diff[31] != a[31]), a >= b, diff[31], diff == 0};
        e_pc        = epc;
        e_predTaken = ept;
        f_pc        = fpc;

        e.tag       = tag;
        e.pred      = rst ? 1'b0 : (tbl[idx_of(fpc)] >= 2);
        e.pcsrc     = 2'd0;
        e.mis       = 1'b0;
        e.cnt_known = cnt_known;
        e.bc        = bc_m;
        e.mc        = mc_m;
        if (!rst && v) begin
            if (fj) begin
                e.pcsrc = op3 ? 2'd1 : 2'd2;
            end else if (br) begin
                e.mis   = (taken != ept);
                e.pcsrc = (taken && !ept) ? 2'd1 : ((!taken && ept) ? 2'd3 : 2'd0);
            end
        end
        q.push_back(e);

        if (rst) begin
            foreach (tbl[i]) tbl[i] = 1;
            bc_m = 0;
            mc_m = 0;
            cnt_known = 1'b1;
        end else if (v && br && !fj) begin
            k = idx_of(epc);
            tbl[k] = taken ? ((tbl[k] < 3) ? tbl[k] + 1 : 3) : ((tbl[k] > 0) ? tbl[k] - 1 : 0);
            if (bc_m < cnt_max) bc_m++;
            if (e.mis && mc_m < cnt_max) mc_m++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit [31:0] fpc, input string tag);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, fpc, tag);
    endtask

    // Monitor: outputs are presented every cycle; one expectation per cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk({e.tag, ".PCSrc"}, int'(PCSrc), int'(e.pcsrc));
            chk({e.tag, ".mispredict"}, int'(mispredict), int'(e.mis));
            chk({e.tag, ".f_predTaken"}, int'(f_predTaken), int'(e.pred));
            if (e.cnt_known) begin
                chk({e.tag, ".branchCount"}, int'(branchCount), e.bc);
                chk({e.tag, ".mispredCount"}, int'(mispredCount), e.mc);
            end
        end
    end

    initial begin
        bit [31:0] a, b, epc, fpc;
        int        waitc;
        foreach (tbl[i]) tbl[i] = 0;
        @(posedge clk);
        #1;
        // Reset with a live branch on the inputs: outputs forced quiet, update suppressed.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'd5, 32'd5, 32'h100, 1'b0, 32'h100, "rst0");
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'd5, 32'd5, 32'h100, 1'b0, 32'h100, "rst1");

        for (int i = 0; i < int'(ENTRIES); i++) begin
            idle(($urandom << 8) | 32'(i << 2), "sweep");
        end

        // beq taken three times at 0x100, predicted not taken.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'd7, 32'd7, 32'h100, 1'b0, 32'h100, "beq");
        end
        idle(32'h100, "beq_after");

        // bltu not taken (a >= b unsigned), predicted taken.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd6, 32'd9, 32'd3, 32'h40, 1'b1, 32'h40, "bltu");
        idle(32'h40, "bltu_after");

        // Jumps override the branch flag and leave state untouched.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 32'd1, 32'd1, 32'h100, 1'b0, 32'h100, "jalr");
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd1, 32'd1, 32'd1, 32'h100, 1'b1, 32'h100, "jal");
        idle(32'h100, "jump_after");

        // Aliasing 0x100/0x200: same-cycle read sees old value, next cycle the new one.
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 32'd3, 32'd3, 32'h100, 1'b1, 32'h200, "alias");
        end
        idle(32'h200, "alias_after");

        // Saturate branchCount.
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'(i % 2), 32'd4, 32'(i % 3), 32'(i << 2), 1'(i % 3 == 0),
                  32'(i << 2), "sat");
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'd2, 32'd2, 32'h8, 1'b0, 32'h8, "rst_mid");
        for (int i = 0; i < int'(ENTRIES); i++) begin
            idle(32'(i << 2) | 32'h1000, "sweep2");
        end

        // Random traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 0) ? $urandom : a ^ 32'(1 << $urandom_range(0, 31)));
            epc = ($urandom & 32'hFFFF_F000) | ($urandom_range(0, 15) << 2);
            fpc = ($urandom_range(0, 2) == 0) ? epc : (($urandom & 32'hFFFF_F000) | ($urandom_range(0, 15) << 2));
            drive(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 4) == 0), 1'($urandom), 3'($urandom), a, b, epc, 1'($urandom), fpc, "rand");
        end

        waitc = 0;
        while (q.size() != 0 && waitc < 10) begin
            @(posedge clk);
            waitc++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
